// File: rtl/shift_pkg.sv
// Shared opcode encoding, command payload and opcode decode for the shift command stage.
package shift_pkg;

  typedef enum logic [1:0] {
    OP_SRL  = 2'b00,
    OP_SRA  = 2'b01,
    OP_SLL  = 2'b10,
    OP_PASS = 2'b11
  } shift_op_e;

  // Command body; the tag is appended by the stage because its width is a stage parameter.
  typedef struct packed {
    shift_op_e   op;
    logic [31:0] data;
    logic [5:0]  amt;
  } shift_cmd_t;

  typedef struct packed {
    logic       sra;
    logic       sll;
    logic [5:0] size;
  } shift_ctl_t;

  function automatic shift_ctl_t decode_op(input shift_op_e op, input logic [5:0] amt);
    shift_ctl_t ctl;
    ctl.sra  = 1'b0;
    ctl.sll  = 1'b0;
    ctl.size = amt;
    case (op)
      OP_SRA:  ctl.sra  = 1'b1;
      OP_SLL:  ctl.sll  = 1'b1;
      OP_PASS: ctl.size = '0;
      default: ;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/shift_cmd_fifo.sv
// Parameterised synchronous FIFO (DEPTH a power of two, >= 2) holding command entries of type T.
module shift_cmd_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T                mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  // NOTE: storage carries no reset; only pointers and count do, so a stale entry is never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/shift_cmd_stage.sv
// Command FIFO, opcode decode and registered result around an external 64-bit shifter.
// Optional SHIFT_CMD_STATS_EN adds saturating stat_cmds / stat_stalls counters.
module shift_cmd_stage
  import shift_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_data,
  input  logic [5:0]       in_amt,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      sh_in,
  output logic             sh_sra,
  output logic             sh_sll,
  output logic [5:0]       sh_size,
  input  logic [63:0]      sh_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic [TAG_W-1:0] res_tag
`ifdef SHIFT_CMD_STATS_EN
  ,
  output logic [31:0]      stat_cmds,
  output logic [31:0]      stat_stalls
`endif
);

  typedef struct packed {
    shift_cmd_t       cmd;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t     in_entry;
  entry_t     head;
  shift_ctl_t ctl;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       issue;

  assign in_entry.cmd.op   = shift_op_e'(in_op);
  assign in_entry.cmd.data = in_data;
  assign in_entry.cmd.amt  = in_amt;
  assign in_entry.tag      = in_tag;

  // No bypass: a full FIFO refuses input even in a cycle that also issues.
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign issue    = !fifo_empty && (!res_valid || res_ready);

  shift_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (in_entry),
    .pop   (issue),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ctl = decode_op(head.cmd.op, head.cmd.amt);

  // NOTE: every output gets a default first, so no path through the block infers a latch.
  always_comb begin
    sh_in   = '0;
    sh_sra  = 1'b0;
    sh_sll  = 1'b0;
    sh_size = '0;
    if (!fifo_empty) begin
      sh_in   = head.cmd.data;
      sh_sra  = ctl.sra;
      sh_sll  = ctl.sll;
      sh_size = ctl.size;
    end
  end

  // res_data/res_tag only move on issue, so they hold through stalls and after draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_tag   <= '0;
    end else if (issue) begin
      res_valid <= 1'b1;
      res_data  <= sh_out;
      res_tag   <= head.tag;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef SHIFT_CMD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cmds   <= '0;
      stat_stalls <= '0;
    end else begin
      if (push && (stat_cmds != '1)) stat_cmds <= stat_cmds + 1'b1;
      if (res_valid && !res_ready && (stat_stalls != '1)) stat_stalls <= stat_stalls + 1'b1;
    end
  end
`endif

endmodule
